// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel filter with run-time frame size: bypass, clamped
// gradient magnitude, or binary threshold, on valid/ready streams.
module sobel_stream_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_W      = 256,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DIM_WIDTH-1:0]  i_width,
  input  logic [DIM_WIDTH-1:0]  i_height,
  input  logic [1:0]            i_mode,
  input  logic [DATA_WIDTH-1:0] i_thresh,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  o_idle,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int GW = DATA_WIDTH + 4;
  localparam logic [GW-1:0] PIX_MAX = {4'b0000, {DATA_WIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state;
  logic [DIM_WIDTH-1:0]  width, height, row, col;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] thresh;

  // line0 holds the previous row, line1 the row before that
  logic [DATA_WIDTH-1:0] line0 [MAX_W];
  logic [DATA_WIDTH-1:0] line1 [MAX_W];

  // Two older window columns; the newest column comes straight from the inputs
  logic [DATA_WIDTH-1:0] t0, t1, m0, m1, b0, b1;
  logic [DATA_WIDTH-1:0] t2, m2, b2;

  logic                  in_hs, out_fire, last_px, emit, cfg_ok;
  logic [AW-1:0]         col_idx;
  logic signed [GW-1:0]  gx, gy;
  logic [GW-1:0]         mag;
  logic [DATA_WIDTH-1:0] result;

  function automatic logic signed [GW-1:0] ext(input logic [DATA_WIDTH-1:0] v);
    return $signed({4'b0000, v});
  endfunction

  function automatic logic [GW-1:0] absv(input logic signed [GW-1:0] v);
    return v[GW-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  assign col_idx  = col[AW-1:0];
  assign t2       = line1[col_idx];
  assign m2       = line0[col_idx];
  assign b2       = s_data;
  assign s_ready  = (state == RUN) && (!m_valid || m_ready);
  assign in_hs    = s_valid && s_ready;
  assign out_fire = m_valid && m_ready;
  assign last_px  = (col == width - DIM_WIDTH'(1)) && (row == height - DIM_WIDTH'(1));
  assign emit     = (mode == 2'd0) || ((row >= DIM_WIDTH'(2)) && (col >= DIM_WIDTH'(2)));

  assign gx  = (ext(t2) + ext(m2) + ext(m2) + ext(b2)) - (ext(t0) + ext(m0) + ext(m0) + ext(b0));
  assign gy  = (ext(b0) + ext(b1) + ext(b1) + ext(b2)) - (ext(t0) + ext(t1) + ext(t1) + ext(t2));
  assign mag = absv(gx) + absv(gy);

  // Start-cycle legality check of the requested configuration
  always_comb begin
    cfg_ok = 1'b1;
    if ((i_width == '0) || (i_height == '0)) begin
      cfg_ok = 1'b0;
    end else if (i_width > DIM_WIDTH'(MAX_W)) begin
      cfg_ok = 1'b0;
    end else if (i_mode == 2'd3) begin
      cfg_ok = 1'b0;
    end else if ((i_mode != 2'd0) && ((i_width < DIM_WIDTH'(3)) || (i_height < DIM_WIDTH'(3)))) begin
      cfg_ok = 1'b0;
    end else begin
      cfg_ok = 1'b1;
    end
  end

  // Output pixel selection for the latched mode
  always_comb begin
    result = '0;
    case (mode)
      2'd0:    result = s_data;
      2'd1:    result = (mag > PIX_MAX) ? '1 : mag[DATA_WIDTH-1:0];
      2'd2:    result = (mag >= {4'b0000, thresh}) ? '1 : '0;
      default: result = '0;
    endcase
  end

  // Control FSM, frame counters and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      width  <= '0;
      height <= '0;
      mode   <= 2'd0;
      thresh <= '0;
      row    <= '0;
      col    <= '0;
      o_idle <= 1'b1;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && cfg_ok) begin
            width  <= i_width;
            height <= i_height;
            mode   <= i_mode;
            thresh <= i_thresh;
            row    <= '0;
            col    <= '0;
            state  <= RUN;
            o_idle <= 1'b0;
            o_busy <= 1'b1;
          end else if (i_start) begin
            o_err <= 1'b1;
          end
        end
        RUN: begin
          if (in_hs) begin
            if (col == width - DIM_WIDTH'(1)) begin
              col <= '0;
              row <= row + DIM_WIDTH'(1);
            end else begin
              col <= col + DIM_WIDTH'(1);
            end
            if (last_px) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!m_valid || m_ready) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_idle <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          o_idle <= 1'b1;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Single-entry output register with hold under back-pressure
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (in_hs && emit) begin
      m_valid <= 1'b1;
      m_data  <= result;
    end else if (out_fire) begin
      m_valid <= 1'b0;
    end
  end

  // Line buffers and window advance on every accepted pixel
  always_ff @(posedge clk) begin
    if (in_hs) begin
      line1[col_idx] <= line0[col_idx];
      line0[col_idx] <= s_data;
      t0 <= t1;
      t1 <= t2;
      m0 <= m1;
      m1 <= m2;
      b0 <= b1;
      b1 <= b2;
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Self-checking bench: scenario tasks driving frames, checked against a
// frame-level Sobel reference model.
module tb_sobel_stream_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [15:0] i_width, i_height;
  logic [1:0]  i_mode;
  logic [7:0]  i_thresh;
  logic        s_valid, s_ready;
  logic [7:0]  s_data;
  logic        m_valid, m_ready;
  logic [7:0]  m_data;
  logic        o_idle, o_busy, o_done, o_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] frame[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sobel_stream_filter #(.DATA_WIDTH(8), .MAX_W(256), .DIM_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_width(i_width), .i_height(i_height),
    .i_mode(i_mode), .i_thresh(i_thresh), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .o_idle(o_idle), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  function automatic int px(int w, int r, int c);
    return int'(frame[r*w + c]);
  endfunction

  // Reference: bypass copies the frame; filter modes output interior pixels in raster order
  task automatic model(input int w, input int h, input int md, input int thr);
    int gx, gy, mag;
    exp_q.delete();
    if (md == 0) begin
      foreach (frame[i]) exp_q.push_back(frame[i]);
    end else begin
      for (int r = 1; r < h - 1; r++) begin
        for (int c = 1; c < w - 1; c++) begin
          gx = (px(w,r-1,c+1) + 2*px(w,r,c+1) + px(w,r+1,c+1))
             - (px(w,r-1,c-1) + 2*px(w,r,c-1) + px(w,r+1,c-1));
          gy = (px(w,r+1,c-1) + 2*px(w,r+1,c) + px(w,r+1,c+1))
             - (px(w,r-1,c-1) + 2*px(w,r-1,c) + px(w,r-1,c+1));
          mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
          if (md == 1) exp_q.push_back((mag > 255) ? 8'hFF : 8'(mag));
          else         exp_q.push_back((mag >= thr) ? 8'hFF : 8'h00);
        end
      end
    end
  endtask

  task automatic fill_cols(input int w, input int h);
    frame.delete();
    for (int r = 0; r < h; r++) for (int c = 0; c < w; c++) frame.push_back(8'(10*c));
  endtask

  task automatic fill_rand(input int w, input int h);
    frame.delete();
    for (int i = 0; i < w*h; i++) frame.push_back(8'($urandom_range(255)));
  endtask

  task automatic start_frame(input int w, input int h, input int md, input int thr);
    i_width  = 16'(w);
    i_height = 16'(h);
    i_mode   = 2'(md);
    i_thresh = 8'(thr);
    i_start  = 1'b1;
    @(posedge clk); #1;
    i_start  = 1'b0;
  endtask

  // Runs one legal frame end to end and checks outputs, handshake rules and status
  task automatic run_frame(input string name, input int w, input int h, input int md,
                           input int thr, input bit rnd,
                           output int first_in, output int first_out, output int last_out);
    logic [7:0] got[$];
    int idx = 0, cycles = 0, done_seen = 0, done_at = -1;
    int budget = w*h*8 + 100;
    bit hs, prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    first_in = -1; first_out = -1; last_out = -1;
    model(w, h, md, thr);
    start_frame(w, h, md, thr);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL %s start: o_busy=%0b expected 1", name, o_busy); end
    while (cycles < budget && done_at < 0) begin
      s_valid = (idx < w*h) && (rnd ? ($urandom_range(3) != 0) : 1'b1);
      s_data  = (idx < w*h) ? frame[idx] : 8'h00;
      m_ready = rnd ? ($urandom_range(2) != 0) : 1'b1;
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          errors++; $display("FAIL %s hold: m_valid=%0b m_data=%0d expected 1/%0d", name, m_valid, m_data, prev_data);
        end
      end
      if (m_valid && !m_ready) begin
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL %s stall: s_ready=%0b expected 0", name, s_ready); end
      end
      hs = s_valid && s_ready;
      if (hs && first_in < 0) first_in = cycles;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        if (first_out < 0) first_out = cycles;
        last_out = cycles;
      end
      if (o_done) begin done_seen++; done_at = cycles; end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      @(posedge clk); #1;
      if (hs) idx++;
      cycles++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    checks++;
    if (done_seen != 1) begin errors++; $display("FAIL %s done: pulses=%0d expected 1 (timeout)", name, done_seen); end
    checks++;
    if (idx != w*h) begin errors++; $display("FAIL %s inputs: accepted=%0d expected %0d", name, idx, w*h); end
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL %s count: got %0d expected %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++; $display("FAIL %s pixel[%0d]: got %0d expected %0d", name, i, got[i], exp_q[i]);
      end
    end
    if (last_out >= 0) begin
      checks++;
      if (done_at <= last_out) begin errors++; $display("FAIL %s done_timing: done=%0d last_out=%0d", name, done_at, last_out); end
    end
    checks++;
    if (o_idle !== 1'b1 || o_done !== 1'b0) begin
      errors++; $display("FAIL %s after_done: o_idle=%0b o_done=%0b expected 1/0", name, o_idle, o_done);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_ready, m_valid, o_busy, o_done, o_err, o_idle} !== 6'b000001 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL reset: s_ready=%0b m_valid=%0b busy=%0b done=%0b err=%0b idle=%0b data=%0d expected 0,0,0,0,0,1,0",
               s_ready, m_valid, o_busy, o_done, o_err, o_idle, m_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_idle !== 1'b1) begin errors++; $display("FAIL reset_release: o_idle=%0b expected 1", o_idle); end
  endtask

  task automatic test_magnitude;
    int a, b, c;
    fill_cols(5, 5);
    run_frame("mag5x5", 5, 5, 1, 0, 1'b0, a, b, c);
  endtask

  // Two frames started back to back, on the threshold boundary
  task automatic test_back_to_back_thresh;
    int a, b, c;
    fill_cols(5, 5);
    run_frame("thr80", 5, 5, 2, 80, 1'b0, a, b, c);
    run_frame("thr81", 5, 5, 2, 81, 1'b0, a, b, c);
  endtask

  task automatic test_bypass;
    int fi, fo, lo;
    frame.delete();
    for (int i = 0; i < 10000; i++) frame.push_back(8'(i));
    run_frame("bypass", 100, 100, 0, 0, 1'b0, fi, fo, lo);
    checks++;
    if (fo - fi != 1) begin errors++; $display("FAIL bypass latency: got %0d expected 1", fo - fi); end
    checks++;
    if (lo - fo != 9999) begin errors++; $display("FAIL bypass throughput: span %0d expected 9999", lo - fo); end
  endtask

  task automatic test_step_edge;
    int a, b, c;
    frame.delete();
    for (int r = 0; r < 6; r++) for (int col = 0; col < 8; col++) frame.push_back((col < 4) ? 8'h00 : 8'hFF);
    run_frame("step", 8, 6, 1, 0, 1'b1, a, b, c);
  endtask

  task automatic check_reject(input string name, input int w, input int h, input int md);
    int pulses = 0;
    start_frame(w, h, md, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (o_err !== 1'b1) begin errors++; $display("FAIL %s err_timing: o_err=%0b expected 1", name, o_err); end
      end
      if (o_err) pulses++;
      checks++;
      if (o_busy !== 1'b0 || s_ready !== 1'b0) begin
        errors++; $display("FAIL %s busy: o_busy=%0b s_ready=%0b expected 0/0", name, o_busy, s_ready);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (pulses != 1 || o_idle !== 1'b1) begin
      errors++; $display("FAIL %s err_pulses: got %0d idle=%0b expected 1/1", name, pulses, o_idle);
    end
  endtask

  task automatic test_errors;
    int a, b, c;
    check_reject("w2_mode1", 2, 5, 1);
    check_reject("mode3", 5, 5, 3);
    check_reject("w0_mode0", 0, 4, 0);
    check_reject("h2_mode2", 5, 2, 2);
    check_reject("w257", 257, 2, 0);
    fill_rand(256, 3);
    run_frame("w256_mode1", 256, 3, 1, 0, 1'b0, a, b, c);
    fill_rand(2, 2);
    run_frame("w2_mode0", 2, 2, 0, 0, 1'b1, a, b, c);
  endtask

  task automatic test_mid_reset;
    int a, b, c;
    start_frame(5, 5, 1, 0);
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      s_data = 8'($urandom_range(255));
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || o_idle !== 1'b1 || o_busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL midreset: m_valid=%0b idle=%0b busy=%0b s_ready=%0b expected 0,1,0,0",
                         m_valid, o_idle, o_busy, s_ready);
    end
    @(posedge clk); #1;
    fill_cols(5, 5);
    run_frame("after_reset", 5, 5, 1, 0, 1'b0, a, b, c);
  endtask

  task automatic test_random;
    int w, h, md, a, b, c;
    for (int k = 0; k < 8; k++) begin
      w  = (k == 0) ? 3 : int'($urandom_range(14, 3));
      h  = (k == 0) ? 3 : int'($urandom_range(10, 3));
      md = int'($urandom_range(2, 0));
      fill_rand(w, h);
      run_frame($sformatf("rand%0d_m%0d_%0dx%0d", k, md, w, h), w, h, md, int'($urandom_range(255)), 1'b1, a, b, c);
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_width = 16'd0; i_height = 16'd0; i_mode = 2'd0;
    i_thresh = 8'd0; s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b0;
    test_reset;
    test_magnitude;
    test_back_to_back_thresh;
    test_bypass;
    test_step_edge;
    test_errors;
    test_mid_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_stream_filter.md
# sobel_stream_filter

Parametrised streaming 3x3 Sobel filter, the successor to the fixed 100x100 BRAM-to-BRAM Sobel datapath. It accepts one pixel per cycle on a valid/ready input stream and emits filtered pixels on a valid/ready output stream. Frame width and height are set at run time, up to a synthesis-time maximum, and the block is unaware of memory. The block has three modes: bypass, clamped gradient magnitude, and binary threshold. It sits between a BRAM read sequencer and a BRAM write sequencer under the top-level control FSM.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- MAX_W, 256, maximum frame width; sets the line-buffer depth.
- DIM_WIDTH, 16, width of the dimension inputs and internal counters.

Ports:
- clk  in  1  the single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  start request; accepted only in IDLE.
- i_width  in  DIM_WIDTH  frame width, latched on the start cycle.
- i_height  in  DIM_WIDTH  frame height, latched on the start cycle.
- i_mode  in  2  mode: 0 bypass, 1 magnitude, 2 threshold, 3 reserved (treated as error).
- i_thresh  in  DATA_WIDTH  threshold value, latched on the start cycle.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input ready.
- s_data  in  DATA_WIDTH  input pixel, raster order.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  output pixel.
- o_idle  out  1  high in IDLE.
- o_busy  out  1  high in RUN or DRAIN.
- o_done  out  1  one-cycle pulse at frame end.
- o_err  out  1  one-cycle pulse when a start is rejected.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when i_start=1 and the configuration is legal. The block latches width, height, mode and threshold, and clears the row/column counters.
- Illegal configuration, checked on the start cycle:
  - width=0 or height=0 in any mode, or
  - width>MAX_W in any mode, or
  - width<3 or height<3 in modes 1/2, or
  - mode=3.
  - Response: o_err pulses in the cycle after the start; the FSM stays in IDLE.
- RUN: the block accepts width*height pixels. The column counter wraps to 0 at width-1 and increments the row counter.
- Line buffers: two rows of MAX_W x DATA_WIDTH, plus a 3x3 window shift register. Both update only on an input handshake.
- Bypass: every input pixel is forwarded unchanged, width*height outputs.
- Modes 1/2: an output is produced only when the accepted pixel is at (r,c) with r>=2 and c>=2. That output is the window centred on (r-1,c-1). Interior-only output, (width-2)*(height-2) pixels, raster order.
- Gradients:
  - Gx = (p02+2p12+p22) - (p00+2p10+p20).
  - Gy = (p20+2p21+p22) - (p00+2p01+p02).
  - Both are signed, DATA_WIDTH+4 bits.
- Magnitude: mag = |Gx|+|Gy|, unsigned DATA_WIDTH+4 bits, maximum 8*(2^DATA_WIDTH-1).
  - Mode 1: m_data = min(mag, 2^DATA_WIDTH-1).
  - Mode 2: m_data = all ones if mag >= i_thresh, else 0. The comparison uses the unclamped mag.
- RUN -> DRAIN on the handshake of the last input pixel.
- DRAIN -> DONE when the output register is empty (m_valid=0, or m_valid&m_ready in that cycle).
- DONE: o_done=1 for exactly one cycle, then IDLE.
- i_start outside IDLE is ignored; o_err is not raised.
- Reset mid-frame: the FSM returns to IDLE and the counters and output register clear. Stale line-buffer contents are never used, because windows require r>=2 in the new frame.

## Timing
- Reset values: s_ready=0, m_valid=0, m_data=0, o_busy=0, o_done=0, o_err=0, o_idle=1.
- s_ready = (state==RUN) & (~m_valid | m_ready). A full-throughput pass-through is permitted.
- Latency: m_valid rises the cycle after the input handshake that completes the window (bypass: the cycle after any handshake). Latency is 1 cycle.
- m_data and m_valid are held stable while m_valid=1 and m_ready=0.
- Sustained throughput is 1 pixel/cycle when s_valid=m_ready=1.
- o_done falls at least 1 cycle after the final output handshake. o_idle rises the cycle after o_done.
- Minimum restart: i_start is accepted in the first IDLE cycle after DONE.

## Test plan
- 5x5 frame, mode 1, pixel=10*col, m_ready=1 -> exactly 9 outputs, each 80; o_done pulses once; o_idle returns.
- Same frame, mode 2: i_thresh=80 -> 9 outputs of 255; i_thresh=81 -> 9 outputs of 0.
- 100x100 frame, mode 0, pixel=i mod 256 -> 10000 outputs identical to the inputs, in order, 1 per cycle, first output 1 cycle after the first handshake.
- 8x6 step edge (columns 0-3 = 0, columns 4-7 = 255), mode 1, random m_ready and s_valid -> 24 outputs; the edge columns clamp to 255, flat regions give 0; no loss or duplication; s_ready=0 whenever m_valid&~m_ready.
- Start with width=2 in mode 1, and separately with mode=3 -> o_err pulses once, o_busy stays 0, no s_ready.
- rst asserted mid-frame, then a new 5x5 mode-1 frame -> the new frame gives exactly 9 outputs of 80, with no residue from the aborted frame.
